vending_machine_multi: RTL and testbench
========================================

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 The block SHALL have parameter N_PROD, default 4, meaning number of selectable products.
REQ-002 The block SHALL have parameter CREDIT_W, default 6, meaning credit width in 5-tk units.
REQ-003 The block SHALL have parameter PRICES, default {6'd5,6'd2,6'd4,6'd3}, meaning packed N_PROD*CREDIT_W price table in 5-tk units, where product 0 is the LSB field (15/20/10/25 tk).
REQ-004 The block SHALL have parameter MAX_CREDIT, default 40, meaning the credit ceiling in units (200 tk).
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning the idle-credit timeout in cycles, used only with VEND_TIMEOUT_EN.
REQ-006 The block SHALL have port clock, input, 1 bit, meaning system clock, with all logic on posedge.
REQ-007 The block SHALL have port reset, input, 1 bit, meaning reset, synchronous, active-high.
REQ-008 The block SHALL have ports coin_valid (input, 1) and coin_val (input, 2), meaning a coin strobe with coin code 00=5, 01=10, 10=20, 11=50 tk (1/2/4/10 units).
REQ-009 The block SHALL have ports sel_valid (input, 1) and sel_id (input, clog2(N_PROD)), meaning a product selection strobe and its index.
REQ-010 The block SHALL have port cancel, input, 1 bit, meaning a request to refund all credit.
REQ-011 The block SHALL have ports change_ready (input, 1), change_valid (output, 1) and change_coin (output, 2), meaning the change-dispense handshake using the coin code of REQ-008.
REQ-012 The block SHALL have ports vend (output, 1) and vend_id (output, clog2(N_PROD)), meaning a one-cycle dispense pulse and the dispensed product index.
REQ-013 The block SHALL have pulse outputs coin_reject, short_funds and timeout, each 1 bit.
REQ-014 The block SHALL have output credit (CREDIT_W) holding the current credit and output state (2 bits) holding the FSM state.

Function
REQ-015 The FSM SHALL have four states: IDLE=00 (credit 0), CREDIT=01 (credit >0), VEND=10 and CHANGE=11.
REQ-016 In IDLE/CREDIT, an accepted coin SHALL add its value to credit, visible one cycle later, and move the FSM to CREDIT.
REQ-017 A coin that would make credit exceed MAX_CREDIT SHALL be rejected: credit is unchanged and coin_reject pulses for 1 cycle.
REQ-018 In VEND/CHANGE, or when coin_valid coincides with sel_valid or cancel, the coin SHALL be rejected with a coin_reject pulse.
REQ-019 Event priority in a single cycle SHALL be cancel > sel_valid > coin_valid.
REQ-020 On sel_valid with credit >= PRICES[sel_id], the FSM SHALL enter VEND; in that VEND cycle vend=1, vend_id=sel_id and credit=credit-price.
REQ-021 The state after VEND SHALL be CHANGE if the remaining credit is >0, else IDLE.
REQ-022 On sel_valid with insufficient credit, or with sel_id>=N_PROD, short_funds SHALL pulse for 1 cycle and state and credit SHALL be unchanged.
REQ-023 Cancel with credit>0 SHALL enter CHANGE; cancel with credit=0 SHALL have no effect.
REQ-024 In CHANGE, the block SHALL present the largest coin <= credit (greedy order 50/20/10/5) on change_coin with change_valid=1, holding both stable until change_ready.
REQ-025 On change_valid&&change_ready, credit SHALL decrement by the coin value; when credit reaches 0 the FSM SHALL enter IDLE and change_valid SHALL deassert.
REQ-026 sel_valid and cancel SHALL be ignored in VEND/CHANGE.
REQ-027 Credit arithmetic SHALL be unsigned CREDIT_W bits, with no wrap possible given REQ-017.

Reset
REQ-028 When reset=1 at posedge, state=IDLE and credit=0 SHALL hold, and all pulses, change_valid, vend_id and change_coin SHALL be 0, overriding any in-progress VEND/CHANGE; any pending refund is discarded.
REQ-029 The timeout counter SHALL reset to 0.

Configuration
REQ-030 Macro VEND_TIMEOUT_EN defined: in CREDIT, after TIMEOUT_CYC consecutive cycles with no coin_valid, sel_valid or cancel, timeout SHALL pulse 1 cycle and the FSM SHALL enter CHANGE to refund all credit; any such input SHALL clear the counter.
REQ-031 Macro VEND_TIMEOUT_EN undefined: no counter SHALL be present, timeout SHALL be tied 0, and credit SHALL be held indefinitely.

Verification
REQ-032 From reset, coin 10 tk then 10 tk, then sel_id=0 (15 tk) -> vend=1 with vend_id=0, then change_coin=00 (5 tk) presented once, then IDLE with credit 0.
REQ-033 Coin 50 tk, then sel_id=2 (10 tk), with change_ready always 1 -> vend, then change coins 20, 20, then IDLE.
REQ-034 Coin 5 tk, then sel_id=3 (25 tk) -> short_funds pulse, credit stays 1; then cancel -> one 5-tk change coin, then IDLE.
REQ-035 Credit 38 units, then coin 20 tk -> coin_reject and credit stays 38; coin_valid together with sel_valid -> coin_reject and the sel is processed.
REQ-036 change_ready held 0 for 5 cycles in CHANGE -> change_valid and change_coin stable; reset asserted mid-CHANGE -> next cycle IDLE, credit 0, change_valid 0.
REQ-037 With VEND_TIMEOUT_EN and TIMEOUT_CYC=8, coin 10 tk then 8 idle cycles -> timeout pulse, then refund 10 tk, then IDLE.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-product vending machine controller.
// Accepts 5/10/20/50 tk coins into a unit credit register (1 unit = 5 tk), vends a
// selected product when credit covers its price, and returns change one coin at a
// time over a valid/ready handshake, largest coin first.
// Optional feature: define VEND_TIMEOUT_EN to refund idle credit after TIMEOUT_CYC cycles.
module vending_machine_multi #(
   parameter int unsigned N_PROD      = 4,
   parameter int unsigned CREDIT_W    = 6,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {6'd5, 6'd2, 6'd4, 6'd3},
   parameter int unsigned MAX_CREDIT  = 40,
   parameter int unsigned TIMEOUT_CYC = 1000,
   localparam int unsigned SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [1:0]          coin_val,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel_id,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   output logic                vend,
   output logic [SEL_W-1:0]    vend_id,
   output logic                coin_reject,
   output logic                short_funds,
   output logic                timeout,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StCredit = 2'b01,
      StVend   = 2'b10,
      StChange = 2'b11
   } state_e;

   state_e              state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic                change_valid_q;
   logic [1:0]          change_coin_q;
   logic                vend_q;
   logic [SEL_W-1:0]    vend_id_q;
   logic                coin_reject_q;
   logic                short_funds_q;

   logic [CREDIT_W-1:0] coin_units;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_in_range;
   logic                sel_affordable;
   logic [CREDIT_W-1:0] change_left;
   logic                timeout_hit;

   // Unit value of a coin code: 00=1, 01=2, 10=4, 11=10.
   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
      case (code)
         2'b00:   coin_value = CREDIT_W'(1);
         2'b01:   coin_value = CREDIT_W'(2);
         2'b10:   coin_value = CREDIT_W'(4);
         default: coin_value = CREDIT_W'(10);
      endcase
   endfunction

   // Largest coin not exceeding the remaining credit.
   function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] amount);
      if (amount >= CREDIT_W'(10))     greedy_code = 2'b11;
      else if (amount >= CREDIT_W'(4)) greedy_code = 2'b10;
      else if (amount >= CREDIT_W'(2)) greedy_code = 2'b01;
      else                             greedy_code = 2'b00;
   endfunction

   // Coin acceptance: the widened sum cannot wrap, so the ceiling compare is exact.
   always_comb begin
      coin_units = coin_value(coin_val);
      coin_sum   = {1'b0, credit_q} + {1'b0, coin_units};
      coin_fits  = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
   end

   // Price lookup; an out-of-range index is never affordable.
   always_comb begin
      sel_price    = '0;
      sel_in_range = 1'b0;
      for (int i = 0; i < int'(N_PROD); i++) begin
         if (sel_id == SEL_W'(i)) begin
            sel_price    = PRICES[i*CREDIT_W +: CREDIT_W];
            sel_in_range = 1'b1;
         end
      end
      sel_affordable = sel_in_range && (credit_q >= sel_price);
   end

   // Credit remaining once the presented change coin is taken.
   always_comb begin
      change_left = credit_q - coin_value(change_coin_q);
   end

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] idle_cnt_q;
   logic            timeout_q;
   logic            idle_now;

   assign idle_now    = (state_q == StCredit) && !coin_valid && !sel_valid && !cancel;
   assign timeout_hit = idle_now && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));
   assign timeout     = timeout_q;

   // Count consecutive input-free cycles spent holding credit.
   always_ff @(posedge clock) begin
      if (reset) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         if (!idle_now || timeout_hit) idle_cnt_q <= '0;
         else                          idle_cnt_q <= idle_cnt_q + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout     = 1'b0;
`endif

   // Main controller: state, credit and all registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StIdle;
         credit_q       <= '0;
         change_valid_q <= 1'b0;
         change_coin_q  <= 2'b00;
         vend_q         <= 1'b0;
         vend_id_q      <= '0;
         coin_reject_q  <= 1'b0;
         short_funds_q  <= 1'b0;
      end else begin
         vend_q        <= 1'b0;
         vend_id_q     <= '0;
         coin_reject_q <= 1'b0;
         short_funds_q <= 1'b0;
         case (state_q)
            StIdle, StCredit: begin
               // A coin loses to any simultaneous command and to the ceiling.
               if (coin_valid && (sel_valid || cancel || !coin_fits)) coin_reject_q <= 1'b1;
               if ((cancel && credit_q != '0) || timeout_hit) begin
                  state_q        <= StChange;
                  change_valid_q <= 1'b1;
                  change_coin_q  <= greedy_code(credit_q);
               end else if (sel_valid) begin
                  if (sel_affordable) begin
                     state_q   <= StVend;
                     vend_q    <= 1'b1;
                     vend_id_q <= sel_id;
                     credit_q  <= credit_q - sel_price;
                  end else begin
                     short_funds_q <= 1'b1;
                  end
               end else if (coin_valid && coin_fits && !cancel) begin
                  credit_q <= coin_sum[CREDIT_W-1:0];
                  state_q  <= StCredit;
               end
            end
            StVend: begin
               coin_reject_q <= coin_valid;
               if (credit_q != '0) begin
                  state_q        <= StChange;
                  change_valid_q <= 1'b1;
                  change_coin_q  <= greedy_code(credit_q);
               end else begin
                  state_q <= StIdle;
               end
            end
            default: begin
               coin_reject_q <= coin_valid;
               if (change_valid_q && change_ready) begin
                  credit_q <= change_left;
                  if (change_left == '0) begin
                     state_q        <= StIdle;
                     change_valid_q <= 1'b0;
                     change_coin_q  <= 2'b00;
                  end else begin
                     change_coin_q <= greedy_code(change_left);
                  end
               end
            end
         endcase
      end
   end

   assign state        = state_q;
   assign credit       = credit_q;
   assign change_valid = change_valid_q;
   assign change_coin  = change_coin_q;
   assign vend         = vend_q;
   assign vend_id      = vend_id_q;
   assign coin_reject  = coin_reject_q;
   assign short_funds  = short_funds_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: directed scenarios plus a randomized
// run checked against a transaction-level credit/refund model.
module tb_vending_machine_multi;

   logic       clock = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_val;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       cancel;
   logic       change_ready;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       vend;
   logic [1:0] vend_id;
   logic       coin_reject;
   logic       short_funds;
   logic       timeout;
   logic [5:0] credit;
   logic [1:0] state;

   int n_cmp = 0;
   int n_err = 0;

   // Product prices in units, product 0 first.
   int prices[4] = '{3, 4, 2, 5};

   string got_s;
   int    stable_err;
   bit    drain_expired;

   vending_machine_multi #(
      .TIMEOUT_CYC(8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_valid    (sel_valid),
      .sel_id       (sel_id),
      .cancel       (cancel),
      .change_ready (change_ready),
      .change_valid (change_valid),
      .change_coin  (change_coin),
      .vend         (vend),
      .vend_id      (vend_id),
      .coin_reject  (coin_reject),
      .short_funds  (short_funds),
      .timeout      (timeout),
      .credit       (credit),
      .state        (state)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic int coin_units_of(input int code);
      case (code)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 10;
      endcase
   endfunction

   // Expected refund as a list of coin codes, largest coins first.
   function automatic string refund_str(input int units);
      string s = "";
      int    u = units;
      while (u >= 10) begin s = {s, "3 "}; u -= 10; end
      while (u >= 4)  begin s = {s, "2 "}; u -= 4;  end
      while (u >= 2)  begin s = {s, "1 "}; u -= 2;  end
      while (u >= 1)  begin s = {s, "0 "}; u -= 1;  end
      return s;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
      coin_val   = 2'b00;
      sel_id     = 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      change_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic put_coin(input int code);
      coin_valid = 1'b1;
      coin_val   = 2'(code);
      step();
      idle_inputs();
   endtask

   // Collect change coins until the machine leaves CHANGE; records coin list and stability.
   task automatic drain_change(input bit always_ready);
      int         cyc = 0;
      bit         prev_wait = 1'b0;
      logic [1:0] prev_coin = 2'b00;
      got_s = "";
      stable_err = 0;
      while (state == 2'b11 && cyc < 300) begin
         if (change_valid !== 1'b1) stable_err++;
         if (prev_wait && change_coin !== prev_coin) stable_err++;
         change_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
         if (change_ready) got_s = {got_s, $sformatf("%0d ", change_coin)};
         prev_wait = !change_ready;
         prev_coin = change_coin;
         step();
         cyc++;
      end
      change_ready = 1'b0;
      drain_expired = (cyc >= 300);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({state, credit, change_valid, change_coin, vend, vend_id} !== 14'd0) begin
         n_err++;
         $display("FAIL reset_state: got st=%0d cr=%0d cv=%0b cc=%0d v=%0b vid=%0d, want all 0",
                  state, credit, change_valid, change_coin, vend, vend_id);
      end
      n_cmp++;
      if ({coin_reject, short_funds, timeout} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_pulses: got %b want 000", {coin_reject, short_funds, timeout});
      end
   endtask

   // 10 + 10 tk, buy 15 tk product, one 5 tk coin back.
   task automatic test_vend_with_change();
      do_reset();
      put_coin(1);
      put_coin(1);
      n_cmp++;
      if ({state, credit} !== {2'd1, 6'd4}) begin
         n_err++;
         $display("FAIL two_coins: got st=%0d cr=%0d want st=1 cr=4", state, credit);
      end
      sel_valid = 1'b1; sel_id = 2'd0;
      step();
      idle_inputs();
      n_cmp++;
      if ({state, credit, vend, vend_id} !== {2'd2, 6'd1, 1'b1, 2'd0}) begin
         n_err++;
         $display("FAIL vend_p0: got st=%0d cr=%0d v=%0b id=%0d want 2/1/1/0",
                  state, credit, vend, vend_id);
      end
      step();
      n_cmp++;
      if ({state, change_valid, change_coin, vend} !== {2'd3, 1'b1, 2'd0, 1'b0}) begin
         n_err++;
         $display("FAIL change_entry: got st=%0d cv=%0b cc=%0d v=%0b want 3/1/0/0",
                  state, change_valid, change_coin, vend);
      end
      drain_change(1'b1);
      n_cmp++;
      if (got_s != "0 " || drain_expired || {state, credit, change_valid} !== 9'd0) begin
         n_err++;
         $display("FAIL refund_5: got coins '%s' st=%0d cr=%0d cv=%0b want '0 ' and idle",
                  got_s, state, credit, change_valid);
      end
   endtask

   // 50 tk, buy 10 tk product, receive 20 + 20.
   task automatic test_big_change();
      do_reset();
      put_coin(3);
      sel_valid = 1'b1; sel_id = 2'd2;
      step();
      idle_inputs();
      n_cmp++;
      if ({state, credit, vend, vend_id} !== {2'd2, 6'd8, 1'b1, 2'd2}) begin
         n_err++;
         $display("FAIL vend_p2: got st=%0d cr=%0d v=%0b id=%0d want 2/8/1/2",
                  state, credit, vend, vend_id);
      end
      step();
      drain_change(1'b1);
      n_cmp++;
      if (got_s != "2 2 " || drain_expired || {state, credit} !== 8'd0) begin
         n_err++;
         $display("FAIL refund_40: got coins '%s' st=%0d cr=%0d want '2 2 ' and idle",
                  got_s, state, credit);
      end
   endtask

   // 5 tk is short for 25 tk; cancel refunds the 5 tk.
   task automatic test_short_funds_cancel();
      do_reset();
      put_coin(0);
      sel_valid = 1'b1; sel_id = 2'd3;
      step();
      idle_inputs();
      n_cmp++;
      if ({short_funds, vend, state, credit} !== {1'b1, 1'b0, 2'd1, 6'd1}) begin
         n_err++;
         $display("FAIL short_funds: got sf=%0b v=%0b st=%0d cr=%0d want 1/0/1/1",
                  short_funds, vend, state, credit);
      end
      step();
      n_cmp++;
      if (short_funds !== 1'b0) begin
         n_err++;
         $display("FAIL short_funds_pulse: got %0b want 0 one cycle later", short_funds);
      end
      cancel = 1'b1;
      step();
      idle_inputs();
      drain_change(1'b1);
      n_cmp++;
      if (got_s != "0 " || drain_expired || {state, credit} !== 8'd0) begin
         n_err++;
         $display("FAIL cancel_refund: got coins '%s' st=%0d cr=%0d want '0 ' and idle",
                  got_s, state, credit);
      end
   endtask

   // Ceiling reject at 38 units, and a coin colliding with a selection.
   task automatic test_coin_reject();
      do_reset();
      put_coin(3); put_coin(3); put_coin(3); put_coin(2); put_coin(2);
      n_cmp++;
      if (credit !== 6'd38) begin
         n_err++;
         $display("FAIL credit_38: got %0d want 38", credit);
      end
      put_coin(2);
      n_cmp++;
      if ({coin_reject, credit, state} !== {1'b1, 6'd38, 2'd1}) begin
         n_err++;
         $display("FAIL ceiling_reject: got rej=%0b cr=%0d st=%0d want 1/38/1",
                  coin_reject, credit, state);
      end
      coin_valid = 1'b1; coin_val = 2'd0; sel_valid = 1'b1; sel_id = 2'd0;
      step();
      idle_inputs();
      n_cmp++;
      if ({coin_reject, vend, vend_id, credit} !== {1'b1, 1'b1, 2'd0, 6'd35}) begin
         n_err++;
         $display("FAIL coin_with_sel: got rej=%0b v=%0b id=%0d cr=%0d want 1/1/0/35",
                  coin_reject, vend, vend_id, credit);
      end
      step();
      drain_change(1'b0);
      n_cmp++;
      if (got_s != refund_str(35) || stable_err != 0 || drain_expired) begin
         n_err++;
         $display("FAIL refund_35: got '%s' stab_err=%0d want '%s'",
                  got_s, stable_err, refund_str(35));
      end
   endtask

   // Backpressure holds the offer; reset aborts CHANGE.
   task automatic test_stall_and_reset();
      logic [1:0] first_coin;
      do_reset();
      put_coin(3);
      cancel = 1'b1;
      step();
      idle_inputs();
      first_coin = change_coin;
      n_cmp++;
      if ({state, change_valid, first_coin} !== {2'd3, 1'b1, 2'd3}) begin
         n_err++;
         $display("FAIL cancel_50: got st=%0d cv=%0b cc=%0d want 3/1/3",
                  state, change_valid, first_coin);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if ({change_valid, change_coin, credit} !== {1'b1, 2'd3, 6'd10}) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: got cv=%0b cc=%0d cr=%0d want 1/3/10",
                     i, change_valid, change_coin, credit);
         end
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_cmp++;
      if ({state, credit, change_valid, change_coin} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_mid_change: got st=%0d cr=%0d cv=%0b cc=%0d want 0",
                  state, credit, change_valid, change_coin);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      put_coin(1);
`ifdef VEND_TIMEOUT_EN
      for (int i = 0; i < 7; i++) begin
         step();
         n_cmp++;
         if ({timeout, state} !== {1'b0, 2'd1}) begin
            n_err++;
            $display("FAIL timeout_early[%0d]: got to=%0b st=%0d want 0/1", i, timeout, state);
         end
      end
      step();
      n_cmp++;
      if ({timeout, state, change_coin} !== {1'b1, 2'd3, 2'd1}) begin
         n_err++;
         $display("FAIL timeout_fire: got to=%0b st=%0d cc=%0d want 1/3/1",
                  timeout, state, change_coin);
      end
      drain_change(1'b1);
      n_cmp++;
      if (got_s != "1 " || drain_expired || state !== 2'd0) begin
         n_err++;
         $display("FAIL timeout_refund: got '%s' st=%0d want '1 ' and idle", got_s, state);
      end
`else
      for (int i = 0; i < 40; i++) step();
      n_cmp++;
      if ({timeout, state, credit} !== {1'b0, 2'd1, 6'd2}) begin
         n_err++;
         $display("FAIL credit_held: got to=%0b st=%0d cr=%0d want 0/1/2", timeout, state, credit);
      end
`endif
   endtask

   // Random transactions against a unit-credit model with greedy refunds.
   task automatic test_random();
      int mc = 0;
      do_reset();
      for (int it = 0; it < 80; it++) begin
         int op = int'($urandom_range(0, 9));
         int code = int'($urandom_range(0, 3));
         int id = int'($urandom_range(0, 3));
         if (op <= 4) begin
            bit rej = (mc + coin_units_of(code)) > 40;
            if (!rej) mc += coin_units_of(code);
            put_coin(code);
            n_cmp++;
            if ({coin_reject, credit, state, timeout} !== {rej, 6'(mc), (mc > 0) ? 2'd1 : 2'd0, 1'b0}) begin
               n_err++;
               $display("FAIL rnd_coin[%0d]: got rej=%0b cr=%0d st=%0d to=%0b want rej=%0b cr=%0d",
                        it, coin_reject, credit, state, timeout, rej, mc);
            end
         end else if (op <= 7) begin
            bit with_coin = (op == 7);
            coin_valid = with_coin; coin_val = 2'(code);
            sel_valid = 1'b1; sel_id = 2'(id);
            step();
            idle_inputs();
            if (mc >= prices[id]) begin
               int rem = mc - prices[id];
               n_cmp++;
               if ({vend, vend_id, credit, state, coin_reject} !==
                   {1'b1, 2'(id), 6'(rem), 2'd2, with_coin}) begin
                  n_err++;
                  $display("FAIL rnd_vend[%0d]: got v=%0b id=%0d cr=%0d st=%0d rej=%0b want id=%0d cr=%0d",
                           it, vend, vend_id, credit, state, coin_reject, id, rem);
               end
               step();
               drain_change(1'b0);
               n_cmp++;
               if (got_s != refund_str(rem) || stable_err != 0 || drain_expired ||
                   {state, credit} !== 8'd0) begin
                  n_err++;
                  $display("FAIL rnd_change[%0d]: got '%s' stab=%0d st=%0d want '%s'",
                           it, got_s, stable_err, state, refund_str(rem));
               end
               mc = 0;
            end else begin
               n_cmp++;
               if ({short_funds, vend, credit, coin_reject} !== {1'b1, 1'b0, 6'(mc), with_coin}) begin
                  n_err++;
                  $display("FAIL rnd_short[%0d]: got sf=%0b v=%0b cr=%0d rej=%0b want cr=%0d",
                           it, short_funds, vend, credit, coin_reject, mc);
               end
            end
         end else if (op == 8) begin
            cancel = 1'b1;
            step();
            idle_inputs();
            drain_change(1'b0);
            n_cmp++;
            if (got_s != refund_str(mc) || stable_err != 0 || drain_expired ||
                {state, credit} !== 8'd0) begin
               n_err++;
               $display("FAIL rnd_cancel[%0d]: got '%s' stab=%0d st=%0d want '%s'",
                        it, got_s, stable_err, state, refund_str(mc));
            end
            mc = 0;
         end else begin
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) step();
            n_cmp++;
            if ({credit, timeout} !== {6'(mc), 1'b0}) begin
               n_err++;
               $display("FAIL rnd_idle[%0d]: got cr=%0d to=%0b want cr=%0d", it, credit, timeout, mc);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      change_ready = 1'b0;
      idle_inputs();
      test_reset();
      test_vend_with_change();
      test_big_change();
      test_short_funds_cancel();
      test_coin_reject();
      test_stall_and_reset();
      test_timeout();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
